// File: rtl/fir_block_serializer.sv
// fir_block_serializer: requantises L-lane FIR output blocks and emits the lanes as one serial stream.
// Ports: i_clk clock; i_reset_n sync active-low reset;
//        i_blk_valid/o_blk_ready/i_blk_data input block handshake (lane 0 = earliest, in the LSBs);
//        o_out_valid/i_out_ready/o_out_data serial requantised sample handshake;
//        o_sat_flag sticky saturation flag; i_sat_clr clears it (a new saturation wins).
module fir_block_serializer #(
    parameter int L              = 3,
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int SHIFT          = 15,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_blk_valid,
    output logic                          o_blk_ready,
    input  logic [L*DATA_IN_WIDTH-1:0]    i_blk_data,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [DATA_OUT_WIDTH-1:0]     o_out_data,
    output logic                          o_sat_flag,
    input  logic                          i_sat_clr
);
    localparam int W  = DATA_IN_WIDTH;
    localparam int OW = DATA_OUT_WIDTH;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam logic signed [W:0] RND  = ((W+1)'(1) << SHIFT) >> 1;
    localparam logic signed [W:0] MAXV = {{(W-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [W:0] MINV = {{(W-OW+2){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            r_state;
    logic [L*W-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [LW-1:0]     r_lane_idx;
    logic              r_out_valid;
    logic [OW-1:0]     r_out_data;
    logic              r_sat;

    logic              w_push;
    logic              w_fire;
    logic              w_last;
    logic              w_pop;
    logic              w_more;
    logic              w_load;
    logic [L*W-1:0]    w_src_blk;
    logic [LW-1:0]     w_src_lane;
    logic [W-1:0]      w_lane_val;
    logic signed [W:0] w_round;
    logic signed [W:0] w_shift;
    logic              w_hi;
    logic              w_lo;
    logic [OW-1:0]     w_q;

    assign o_blk_ready = (r_count != (AW+1)'(FIFO_DEPTH));
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_sat_flag  = r_sat;

    assign w_push = i_blk_valid && o_blk_ready;
    assign w_fire = r_out_valid && i_out_ready;
    assign w_last = (r_lane_idx == LW'(L-1));
    assign w_pop  = w_fire && w_last;
    // another block remains after the pop, counting one pushed this very cycle
    assign w_more = (r_count > (AW+1)'(1)) || w_push;
    assign w_load = (r_state == IDLE && r_count != '0) || (w_fire && (!w_last || w_more));

    // On a pop the next head may be the block arriving this cycle, not yet in memory
    assign w_src_blk  = w_pop ? ((r_count == (AW+1)'(1)) ? i_blk_data : r_mem[r_rd_ptr + AW'(1)])
                              : r_mem[r_rd_ptr];
    assign w_src_lane = (w_fire && !w_last) ? r_lane_idx + LW'(1) : '0;
    assign w_lane_val = w_src_blk[w_src_lane*W +: W];

    // One extra bit keeps the rounding add from wrapping
    assign w_round = $signed({w_lane_val[W-1], w_lane_val}) + RND;
    assign w_shift = w_round >>> SHIFT;
    assign w_hi    = (w_shift > MAXV);
    assign w_lo    = (w_shift < MINV);
    assign w_q     = w_hi ? MAXV[OW-1:0] : w_lo ? MINV[OW-1:0] : w_shift[OW-1:0];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_blk_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lane_idx  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat       <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_sat   <= (w_load && (w_hi || w_lo)) || (r_sat && !i_sat_clr);
            if (w_load) begin
                r_state     <= EMIT;
                r_out_valid <= 1'b1;
                r_out_data  <= w_q;
                r_lane_idx  <= w_src_lane;
            end else if (w_pop) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_lane_idx  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fir_block_serializer.sv
// tb_fir_block_serializer: directed and randomised checks of the block serializer with default parameters.
module tb_fir_block_serializer;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [191:0] blk_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  out_data;
    logic         sat_flag;
    logic         sat_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fir_block_serializer dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_blk_valid (blk_valid),
        .o_blk_ready (blk_ready),
        .i_blk_data  (blk_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_sat_flag  (sat_flag),
        .i_sat_clr   (sat_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] q_model(input logic signed [63:0] x);
        logic signed [64:0] t;
        t = ($signed({x[63], x}) + 65'sd16384) >>> 15;
        if (t > 65'sd32767) return 16'h7FFF;
        if (t < -65'sd32768) return 16'h8000;
        return t[15:0];
    endfunction

    function automatic logic [191:0] mk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        return {c, b, a};
    endfunction

    // Called at a negedge with out_ready=1 and an empty pipeline
    task automatic one_block(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2, input logic es);
        check({tag, ".rdy"}, blk_ready, 1);
        blk_valid = 1'b1;
        blk_data  = mk(a, b, c);
        @(negedge clk);
        blk_valid = 1'b0;
        check({tag, ".lat"}, out_valid, 0);
        @(negedge clk);
        check({tag, ".v0"}, out_valid, 1);
        check({tag, ".d0"}, out_data, e0);
        check({tag, ".sat"}, sat_flag, es);
        @(negedge clk);
        check({tag, ".v1"}, out_valid, 1);
        check({tag, ".d1"}, out_data, e1);
        @(negedge clk);
        check({tag, ".v2"}, out_valid, 1);
        check({tag, ".d2"}, out_data, e2);
        @(negedge clk);
        check({tag, ".end"}, out_valid, 0);
    endtask

    initial begin
        logic signed [63:0] lv [3];
        int got;
        bit started;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst.valid", out_valid, 0);
        check("rst.data", out_data, 0);
        check("rst.ready", blk_ready, 1);
        check("rst.sat", sat_flag, 0);

        one_block("t1", 64'h8000, 64'h4000, 64'h3FFF, 16'd1, 16'd1, 16'd0, 1'b0);
        one_block("t2", -64'sd16384, -64'sd16385, -64'sd32768, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);
        check("t2.sat", sat_flag, 0);
        one_block("t3", 64'sd40000 <<< 15, -(64'sd40000 <<< 15), 64'sd32767 <<< 15,
                  16'h7FFF, 16'h8000, 16'h7FFF, 1'b1);
        check("t3.sticky", sat_flag, 1);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        check("t3.clr", sat_flag, 0);

        out_ready = 1'b0;
        check("t4.rdy1", blk_ready, 1);
        blk_valid = 1'b1;
        blk_data  = mk(64'h8000, 64'h10000, 64'h18000);
        @(negedge clk);
        check("t4.rdy2", blk_ready, 1);
        blk_data  = mk(64'h20000, 64'h28000, 64'h30000);
        @(negedge clk);
        check("t4.full", blk_ready, 0);
        check("t4.v", out_valid, 1);
        check("t4.d", out_data, 1);
        blk_data  = mk(64'h38000, 64'h40000, 64'h48000);
        @(negedge clk);
        check("t4.full2", blk_ready, 0);
        check("t4.hold", out_data, 1);
        out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            @(negedge clk);
            check("t4.sv", out_valid, 1);
            check("t4.sd", out_data, 16'(i));
            if (i == 4) check("t4.reopen", blk_ready, 1);
            if (i == 5) blk_valid = 1'b0;
        end
        @(negedge clk);
        check("t4.end", out_valid, 0);

        got = 0;
        started = 0;
        for (int c = 0; c < 320 && got < 300; c++) begin
            if (c < 300 && c % 3 == 0) begin
                check("t5.rdy", blk_ready, 1);
                for (int k = 0; k < 3; k++) begin
                    lv[k] = $signed({$urandom, $urandom}) >>> $urandom_range(20, 50);
                    exp_q.push_back(q_model(lv[k]));
                end
                blk_valid = 1'b1;
                blk_data  = mk(lv[0], lv[1], lv[2]);
            end else begin
                blk_valid = 1'b0;
            end
            @(negedge clk);
            if (started || out_valid) begin
                started = 1;
                check("t5.gap", out_valid, 1);
                if (out_valid) begin
                    if (exp_q.size() == 0) check("t5.extra", 1, 0);
                    else check("t5.data", out_data, exp_q.pop_front());
                    got++;
                end
            end
        end
        blk_valid = 1'b0;
        check("t5.count", 64'(got), 300);
        @(negedge clk);
        check("t5.idle", out_valid, 0);

        blk_valid = 1'b1;
        blk_data  = mk(64'h8000, 64'h10000, 64'h18000);
        @(negedge clk);
        blk_data  = mk(64'h20000, 64'h28000, 64'h30000);
        @(negedge clk);
        blk_valid = 1'b0;
        check("t6.l0", out_data, 1);
        @(negedge clk);
        check("t6.l1", out_data, 2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("t6.valid", out_valid, 0);
        check("t6.data", out_data, 0);
        check("t6.ready", blk_ready, 1);
        @(negedge clk);
        check("t6.flushed", out_valid, 0);
        one_block("t6.new", 64'h50000, 64'h58000, 64'h60000, 16'd10, 16'd11, 16'd12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
